// File: rtl/elevator_scheduler.sv
// Three-floor elevator scheduler: edge-latched car/hall calls, directional sweep and timed door.
// Define ELEVATOR_IDLE_RETURN_EN to send an idle car back to floor 1 after IDLE_TIMEOUT cycles.
module elevator_scheduler #(
  parameter int unsigned DOOR_CYCLES  = 8,
  parameter int unsigned IDLE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] f,
  input  logic [1:0] u,
  input  logic [1:0] d,
  input  logic [2:0] s,
  output logic [1:0] ac,
  output logic [1:0] display,
  output logic       doorOpen,
  output logic [2:0] pending
);

  typedef enum logic [1:0] {StIdle, StUp, StDown, StDoor} state_e;

  state_e      r_state, w_state_d;
  logic        r_dir, w_dir_d;
  logic [1:0]  r_ac, w_ac_d;
  logic [1:0]  r_display, w_disp_d;
  logic        r_door, w_door_d;
  logic [7:0]  r_cnt, w_cnt_d;
  logic [2:0]  r_car, w_car_d;
  logic [1:0]  r_up, w_up_d;
  logic [1:0]  r_dn, w_dn_d;
  logic [2:0]  r_f_s, r_f_p;
  logic [1:0]  r_u_s, r_u_p, r_d_s, r_d_p;
  logic [2:0]  r_s_q;
  logic        r_arm;

  logic [2:0]  w_f_rise, w_up3, w_dn3, w_at, w_at_calls, w_oh;
  logic [1:0]  w_u_rise, w_d_rise, w_s_fl, w_fl;
  logic        w_s_hit, w_rise_at, w_any_above, w_any_below, w_stop, w_sdir;
  logic [2:0]  w_clr_car, w_clr_up, w_clr_dn, w_block;

`ifdef ELEVATOR_IDLE_RETURN_EN
  logic [15:0] r_idle_cnt, w_idle_d;
  logic        r_homing, w_home_d;
`else
  logic        w_unused_idle;
  assign w_unused_idle = ^IDLE_TIMEOUT;
`endif

  function automatic logic [2:0] fl_oh(input logic [1:0] fl);
    case (fl)
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] above_m(input logic [1:0] fl);
    case (fl)
      2'd1:    return 3'b110;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] below_m(input logic [1:0] fl);
    case (fl)
      2'd2:    return 3'b001;
      2'd3:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // Hall calls mapped onto floor-indexed vectors (no up call at 3, no down call at 1).
  assign w_up3       = {1'b0, r_up};
  assign w_dn3       = {r_dn, 1'b0};
  assign pending     = r_car | w_up3 | w_dn3;
  assign w_f_rise    = r_f_s & ~r_f_p;
  assign w_u_rise    = r_u_s & ~r_u_p;
  assign w_d_rise    = r_d_s & ~r_d_p;
  assign w_at        = fl_oh(r_display);
  assign w_at_calls  = pending & w_at;
  assign w_rise_at   = |((w_f_rise | {1'b0, w_u_rise} | {w_d_rise, 1'b0}) & w_at);
  assign w_any_above = |(pending & above_m(r_display));
  assign w_any_below = |(pending & below_m(r_display));

  // Only a clean single-floor sensor rise counts; overlapping sensors are ignored.
  assign w_s_hit = ((s == 3'b001) || (s == 3'b010) || (s == 3'b100)) && (|(s & ~r_s_q));
  assign w_s_fl  = s[0] ? 2'd1 : (s[1] ? 2'd2 : 2'd3);

  always_comb begin
    w_state_d = r_state;
    w_dir_d   = r_dir;
    w_ac_d    = r_ac;
    w_disp_d  = r_display;
    w_door_d  = r_door;
    w_cnt_d   = r_cnt;
    w_stop    = 1'b0;
    w_fl      = r_display;
    w_sdir    = r_dir;
    w_oh      = 3'b000;
    w_clr_car = 3'b000;
    w_clr_up  = 3'b000;
    w_clr_dn  = 3'b000;
    w_block   = 3'b000;
`ifdef ELEVATOR_IDLE_RETURN_EN
    w_idle_d  = '0;
    w_home_d  = r_homing;
`endif
    if (r_arm) begin
      unique case (r_state)
        StIdle: begin
          if (|w_at_calls) begin
            w_stop = 1'b1;
            // Serve in the opposite sweep if only the other hall call waits here.
            w_sdir = (|((r_car | (r_dir ? w_up3 : w_dn3)) & w_at)) ? r_dir : ~r_dir;
          end else if (w_any_above && (r_dir || !w_any_below)) begin
            w_state_d = StUp;
            w_ac_d    = 2'b10;
            w_dir_d   = 1'b1;
          end else if (w_any_below) begin
            w_state_d = StDown;
            w_ac_d    = 2'b01;
            w_dir_d   = 1'b0;
          end else begin
`ifdef ELEVATOR_IDLE_RETURN_EN
            if (r_display != 2'd1) begin
              if (32'(r_idle_cnt) + 32'd1 >= IDLE_TIMEOUT) begin
                w_state_d = StDown;
                w_ac_d    = 2'b01;
                w_dir_d   = 1'b0;
                w_home_d  = 1'b1;
              end else begin
                w_idle_d  = r_idle_cnt + 16'd1;
              end
            end
`endif
          end
        end
        StUp: begin
          if (w_s_hit) begin
            w_disp_d = w_s_fl;
            if ((|((r_car | w_up3) & fl_oh(w_s_fl))) || !(|(pending & above_m(w_s_fl))) ||
                (w_s_fl == 2'd3)) begin
              w_stop = 1'b1;
              w_fl   = w_s_fl;
              w_sdir = 1'b1;
            end
          end
        end
        StDown: begin
          if (w_s_hit) begin
            w_disp_d = w_s_fl;
`ifdef ELEVATOR_IDLE_RETURN_EN
            if (r_homing && (pending == 3'b000)) begin
              if (w_s_fl == 2'd1) begin
                w_state_d = StIdle;
                w_ac_d    = 2'b00;
                w_home_d  = 1'b0;
              end
            end else
`endif
            if ((|((r_car | w_dn3) & fl_oh(w_s_fl))) || !(|(pending & below_m(w_s_fl))) ||
                (w_s_fl == 2'd1)) begin
              w_stop = 1'b1;
              w_fl   = w_s_fl;
              w_sdir = 1'b0;
            end
          end
        end
        StDoor: begin
          w_block = w_at;
          if (w_rise_at) begin
            w_cnt_d = 8'(DOOR_CYCLES);
          end else if (r_cnt <= 8'd1) begin
            w_state_d = StIdle;
            w_door_d  = 1'b0;
            w_cnt_d   = 8'd0;
          end else begin
            w_cnt_d   = r_cnt - 8'd1;
          end
        end
        default: w_state_d = StIdle;
      endcase

      if (w_stop) begin
        w_state_d = StDoor;
        w_ac_d    = 2'b00;
        w_door_d  = 1'b1;
        w_cnt_d   = 8'(DOOR_CYCLES);
        w_oh      = fl_oh(w_fl);
        w_clr_car = w_oh;
`ifdef ELEVATOR_IDLE_RETURN_EN
        w_home_d  = 1'b0;
`endif
        if (w_sdir) begin
          w_clr_up = w_oh;
          w_dir_d  = |(pending & above_m(w_fl));
          if (!w_dir_d) w_clr_dn = w_oh;
        end else begin
          w_clr_dn = w_oh;
          w_dir_d  = !(|(pending & below_m(w_fl)));
          if (w_dir_d) w_clr_up = w_oh;
        end
      end
    end
    // A new rise beats a same-edge clear, except at the open-door floor.
    w_car_d = (r_car & ~w_clr_car) | (w_f_rise & ~w_block);
    w_up_d  = (r_up & ~w_clr_up[1:0]) | (w_u_rise & ~w_block[1:0]);
    w_dn_d  = (r_dn & ~w_clr_dn[2:1]) | (w_d_rise & ~w_block[2:1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_dir      <= 1'b1;
      r_ac       <= 2'b00;
      r_display  <= 2'd1;
      r_door     <= 1'b0;
      r_cnt      <= 8'd0;
      r_car      <= 3'b000;
      r_up       <= 2'b00;
      r_dn       <= 2'b00;
      r_f_s      <= 3'b000;
      r_f_p      <= 3'b000;
      r_u_s      <= 2'b00;
      r_u_p      <= 2'b00;
      r_d_s      <= 2'b00;
      r_d_p      <= 2'b00;
      r_s_q      <= 3'b000;
      r_arm      <= 1'b0;
`ifdef ELEVATOR_IDLE_RETURN_EN
      r_idle_cnt <= '0;
      r_homing   <= 1'b0;
`endif
    end else begin
      r_arm      <= 1'b1;
      r_f_s      <= f;
      r_u_s      <= u;
      r_d_s      <= d;
      // First edge after reset preloads both stages so held-high inputs never look like a rise.
      r_f_p      <= r_arm ? r_f_s : f;
      r_u_p      <= r_arm ? r_u_s : u;
      r_d_p      <= r_arm ? r_d_s : d;
      r_s_q      <= s;
      r_state    <= w_state_d;
      r_dir      <= w_dir_d;
      r_ac       <= w_ac_d;
      r_display  <= w_disp_d;
      r_door     <= w_door_d;
      r_cnt      <= w_cnt_d;
      r_car      <= w_car_d;
      r_up       <= w_up_d;
      r_dn       <= w_dn_d;
`ifdef ELEVATOR_IDLE_RETURN_EN
      r_idle_cnt <= w_idle_d;
      r_homing   <= w_home_d;
`endif
    end
  end

  assign ac       = r_ac;
  assign display  = r_display;
  assign doorOpen = r_door;

endmodule
